// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and parity modes shared by the UART blocks.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
   localparam int UART_PARITY_NONE = 0;
   localparam int UART_PARITY_ODD  = 1;
   localparam int UART_PARITY_EVEN = 2;
   typedef enum logic [2:0] {
      ST_WAIT_HIGH,
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_rx_state_t;
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: 2-flop synchroniser, 3-sample history, majority vote and falling-edge strobe.
module uart_bit_sampler (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic level,
   output logic maj,
   output logic fall
);
   logic s1, s2;
   logic [1:0] h;
   // Clearing low holds the receiver in WAIT_HIGH until the real line is seen, with no spurious edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         h  <= 2'b00;
      end else begin
         s1 <= rx;
         s2 <= s1;
         h  <= {h[0], s2};
      end
   end
   always_comb begin
      level = s2;
      maj   = (s2 & h[0]) | (s2 & h[1]) | (h[0] & h[1]);
      fall  = h[0] & ~s2;
   end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with valid/ready output and error flags.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 100,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int PARITY      = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] HALF  = CW'(CLK_PER_BIT / 2);
   localparam logic [CW-1:0] LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);
   if (CLK_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY < UART_PARITY_NONE || PARITY > UART_PARITY_EVEN) begin : g_bad_cfg
      $error("uart_rx_frame: unsupported parameter set");
   end
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_ON = PARITY != UART_PARITY_NONE;
   localparam bit PAR_ODD = PARITY == UART_PARITY_ODD;
`endif
   uart_rx_state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   logic [DATA_BITS-1:0] sh;
   logic ferr_acc, level, maj, fall, mid, done, fe_now, free, take;
   uart_bit_sampler u_smp (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .level(level),
      .maj  (maj),
      .fall (fall)
   );
   always_comb begin
      mid    = cnt == HALF;
      fe_now = ferr_acc | ~maj;
      done   = state == ST_STOP && mid && idx == SLAST;
      free   = ~rx_valid | rx_ready;
      take   = rx_valid & rx_ready;
      nxt    = state;
      case (state)
         ST_WAIT_HIGH: nxt = level ? ST_IDLE : ST_WAIT_HIGH;
         ST_IDLE:      nxt = fall ? ST_START : ST_IDLE;
         ST_START:     nxt = !mid ? ST_START : maj ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
         ST_DATA:      if (mid && idx == DLAST) nxt = PAR_ON ? ST_PARITY : ST_STOP;
         ST_PARITY:    if (mid) nxt = ST_STOP;
`else
         ST_DATA:      if (mid && idx == DLAST) nxt = ST_STOP;
`endif
         ST_STOP:      if (done) nxt = fe_now ? ST_WAIT_HIGH : ST_IDLE;
         default:      nxt = ST_WAIT_HIGH;
      endcase
   end
   // Counter free-runs and is only re-phased by a start edge, so every mid-bit lands on HALF.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_WAIT_HIGH;
         busy      <= 1'b0;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         ferr_acc  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= nxt;
         busy  <= nxt != ST_IDLE;
         cnt   <= (state == ST_IDLE && fall) || cnt == LAST ? '0 : cnt + 1'b1;
         if (state == ST_START) begin
            idx      <= '0;
            ferr_acc <= 1'b0;
         end
         if (mid && state == ST_DATA) begin
            sh  <= {maj, sh[DATA_BITS-1:1]};
            idx <= idx == DLAST ? '0 : idx + 1'b1;
         end
         if (mid && state == ST_STOP) begin
            ferr_acc <= fe_now;
            idx      <= idx + 1'b1;
         end
         if (done && free) begin
            rx_valid  <= 1'b1;
            rx_data   <= sh;
            frame_err <= fe_now;
         end else if (take) rx_valid <= 1'b0;
         if (done && !free) overrun <= 1'b1;
         else if (take) overrun <= 1'b0;
      end
   end
`ifdef UART_RX_PARITY_EN
   logic perr_acc;
   always_ff @(posedge clk) begin
      if (rst) begin
         perr_acc   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == ST_START) perr_acc <= 1'b0;
         if (mid && state == ST_PARITY) perr_acc <= ^sh ^ maj ^ PAR_ODD;
         if (done && free) parity_err <= perr_acc;
      end
   end
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, successor to `uart_rx`. Adds:
- configurable data width and stop-bit count;
- optional parity checking;
- majority-of-3 mid-bit sampling, with an input synchroniser;
- false-start rejection;
- framing, parity and overrun error reporting;
- a valid/ready output register instead of a bare `rx_ready` pulse.

It sits between the serial pin and any byte consumer, such as a FIFO or the console mux.

## Interface
- `CLK_PER_BIT`, 100, clock cycles per bit; must be ≥ 8.
- `DATA_BITS`, 8, data bits per frame; 5..9.
- `STOP_BITS`, 1, stop bits; 1 or 2.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even. Only honoured with `UART_RX_PARITY_EN`.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  DATA_BITS  received word, LSB = first bit on line.
- `rx_valid`  out  1  `rx_data` and error flags are valid.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `frame_err`  out  1  a stop bit sampled low; qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`.
- `overrun`  out  1  sticky: a frame completed while the previous one was unconsumed.
- `busy`  out  1  high in any state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. The three most recent synchronised samples feed a majority vote.
- Bit counter is `$clog2(CLK_PER_BIT)` wide and counts 0..CLK_PER_BIT-1.
- A bit's value is the majority vote taken at count `CLK_PER_BIT/2` (integer division).
- States:
  - **WAIT_HIGH**: entered on reset and after a framing error. Stays until the synchronised `rx` is high, then goes to IDLE. This prevents a held-low line or break from retriggering.
  - **IDLE**: a falling edge on synchronised `rx` clears the counter and moves to START.
  - **START**: at mid-bit, a majority of 0 moves to DATA. A majority of 1 is a false start: return to IDLE and report nothing.
  - **DATA**: shifts in DATA_BITS bits, LSB first. Then moves to PARITY if enabled, else STOP.
  - **PARITY**: samples one bit. Error if the XOR of data and parity bit is not 1 for odd, or not 0 for even.
  - **STOP**: samples STOP_BITS bits. Any low sample sets the frame's `frame_err`.
- **Frame completion** happens at the mid-point sample of the last stop bit:
  - If the output register is free (`!rx_valid`, or being consumed this cycle), it loads `rx_data`, `frame_err` and `parity_err`.
  - Otherwise the new frame is dropped, the old word is held, and `overrun` is set.
  - Next state is IDLE, or WAIT_HIGH if `frame_err` is set. The next start edge may arrive immediately.
- **Handshake**:
  - `rx_valid` stays high until `rx_valid && rx_ready`.
  - `rx_data` and the error flags are stable while `rx_valid` is high.
  - A consume and a load in the same cycle leaves `rx_valid` high with the new word.
- `overrun` clears only on the first consume after it was set, or on `rst`.

## Timing
- Reset state: all outputs 0, `rx_data` = 0, state WAIT_HIGH.
- Reset mid-frame abandons the frame; nothing is delivered.
- Start edge detection lags the pin by 2 cycles (synchroniser).
- Each bit sample is taken `CLK_PER_BIT/2` cycles after the bit's nominal start, plus synchroniser lag.
- `rx_valid` rises 1 cycle after the last stop-bit sample.
- Pin start edge to `rx_valid` is roughly `(1 + DATA_BITS + P + STOP_BITS - 1) * CLK_PER_BIT + CLK_PER_BIT/2 + 3` cycles, where P = 1 if parity is enabled.
- No combinational path from `rx_ready` to any output.
- Accepts frames back-to-back at the full line rate.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state and checker are built, and the `PARITY` parameter is honoured.
- Undefined: no PARITY state, `PARITY` is ignored (treated as 0), and `parity_err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - the parity constants `UART_PARITY_NONE/ODD/EVEN`.
  - It is shared with a future parametrised `uart_tx`.
- Sub-module `uart_bit_sampler`: 2-flop synchroniser, 3-sample shift register, majority output and falling-edge strobe.
- The FSM, counter, shifter and output register stay in `uart_rx_frame`.

## Test plan
- Loopback with existing `uart_tx` (CLK_PER_BIT=100): send 0x00..0xFF with `rx_ready` tied to 1. Every `rx_data` must equal the sent byte, with no error flags.
- Glitch test: a 30-cycle low pulse on an idle line (CLK_PER_BIT=100). Must produce no `rx_valid`, and `busy` must return to 0 within 100 cycles.
- Parity, built with `UART_RX_PARITY_EN`, even parity:
  - 0x63 with parity bit 0 → `parity_err`=0;
  - 0x63 with parity bit 1 → `parity_err`=1, `rx_data`=0x63.
- Break: line held low for 20 bit times → one frame with `rx_data`=0x00 and `frame_err`=1. Nothing further until the line returns high, then 0xA5 is received cleanly.
- Overrun: send 0x11 then 0x22 with `rx_ready`=0. Must see `rx_data`=0x11 and `overrun`=1. One `rx_ready` pulse must clear both `overrun` and `rx_valid`.
- Reset mid-frame: assert `rst` for 1 cycle during DATA of 0x5A. No `rx_valid`, all outputs 0. Then 0x3C sent after the line idles is received correctly.
